// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-ported block data memory.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to requester 0.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 10
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif

module dmem_arbiter #(
    parameter int unsigned ADDR_W = `DMEM_BLOCK_ADDR_SIZE,
    parameter int unsigned BLK_W  = `DBLOCK_SIZE_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [BLK_W-1:0]  wdata0,
    output logic              ack0,
    output logic [BLK_W-1:0]  rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BLK_W-1:0]  wdata1,
    output logic              ack1,
    output logic [BLK_W-1:0]  rdata1,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_din,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [BLK_W-1:0]  mem_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              win, win_nxt;
    logic              mem_ren_nxt, mem_wen_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [BLK_W-1:0]  mem_din_nxt;
    logic              ack0_nxt, ack1_nxt;
    logic [BLK_W-1:0]  rdata0_nxt, rdata1_nxt;

    logic              sel1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [BLK_W-1:0]  sel_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // 1 when requester 1 received the most recent ack; reset value favours requester 0
    logic last1, last1_nxt;
`endif

    // Winner selection among the requests visible in IDLE
    always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        sel1 = req1 && (!req0 || !last1);
`else
        sel1 = req1 && !req0;
`endif
        sel_we    = sel1 ? we1    : we0;
        sel_addr  = sel1 ? addr1  : addr0;
        sel_wdata = sel1 ? wdata1 : wdata0;
    end

    // Next-state and next registered-output logic
    always_comb begin
        state_nxt    = state;
        win_nxt      = win;
        mem_ren_nxt  = mem_ren;
        mem_wen_nxt  = mem_wen;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last1_nxt    = last1;
`endif

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win_nxt      = sel1;
                    mem_addr_nxt = sel_addr;
                    mem_din_nxt  = sel_wdata;
                    if (sel_we) begin
                        mem_wen_nxt = 1'b1;
                        state_nxt   = WRITE;
                    end else begin
                        mem_ren_nxt = 1'b1;
                        state_nxt   = READ;
                    end
                end
            end
            READ: begin
                if (mem_ready) begin
                    mem_ren_nxt = 1'b0;
                    state_nxt   = RELEASE;
                    if (win) begin
                        ack1_nxt   = 1'b1;
                        rdata1_nxt = mem_dout;
                    end else begin
                        ack0_nxt   = 1'b1;
                        rdata0_nxt = mem_dout;
                    end
                end
            end
            WRITE: begin
                if (mem_done) begin
                    mem_wen_nxt = 1'b0;
                    state_nxt   = RELEASE;
                    ack1_nxt    = win;
                    ack0_nxt    = !win;
                end
            end
            RELEASE: begin
                mem_ren_nxt = 1'b0;
                mem_wen_nxt = 1'b0;
                state_nxt   = IDLE;
            end
            default: begin
                mem_ren_nxt = 1'b0;
                mem_wen_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (ack0_nxt || ack1_nxt) begin
            last1_nxt = ack1_nxt;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            win      <= 1'b0;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_nxt;
            win      <= win_nxt;
            mem_ren  <= mem_ren_nxt;
            mem_wen  <= mem_wen_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            rdata0   <= rdata0_nxt;
            rdata1   <= rdata1_nxt;
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last1 <= 1'b1;
        end else begin
            last1 <= last1_nxt;
        end
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default `DMEM_BLOCK_ADDR_SIZE: block address width.
REQ-002 SHALL have parameter BLK_W, default `DBLOCK_SIZE_BITS: block data width.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN  input  1  requester N (N=0,1) transaction request, level, held until ackN.
REQ-006 SHALL have ports weN  input  1  requester N transfer type: 1=block write, 0=block read; stable while reqN=1.
REQ-007 SHALL have ports addrN  input  ADDR_W  requester N block address; stable while reqN=1.
REQ-008 SHALL have ports wdataN  input  BLK_W  requester N write block; stable while reqN=1.
REQ-009 SHALL have ports ackN  output  1  one-cycle completion pulse to requester N.
REQ-010 SHALL have ports rdataN  output  BLK_W  read block for requester N; valid in the ackN cycle.
REQ-011 SHALL have port mem_ren / mem_wen  output  1 each  data-memory read/write enables.
REQ-012 SHALL have port mem_addr  output  ADDR_W  and mem_din  output  BLK_W  to data memory.
REQ-013 SHALL have ports mem_ready, mem_done  input  1  and mem_dout  input  BLK_W  from data memory.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, RELEASE; all mem_* and ack outputs registered.
REQ-015 IDLE: SHALL sample req0/req1, select a winner per REQ-022/023, latch its addr/wdata/we and go to READ (we=0) or WRITE (we=1); with no request SHALL stay in IDLE.
REQ-016 READ: SHALL hold mem_ren=1, mem_wen=0, mem_addr latched, until mem_ready=1 is sampled.
REQ-017 On sampling mem_ready=1 SHALL capture mem_dout into the winner's rdata register, pulse the winner's ack next cycle, drop mem_ren and enter RELEASE.
REQ-018 WRITE: SHALL hold mem_wen=1, mem_ren=0, mem_addr and mem_din latched, until mem_done=1, then pulse the winner's ack, drop mem_wen and enter RELEASE.
REQ-019 RELEASE: SHALL drive mem_ren=mem_wen=0 for exactly one cycle (restarts memory delay counter), then return to IDLE.
REQ-020 SHALL never assert mem_ren and mem_wen in the same cycle.
REQ-021 mem_addr/mem_din SHALL not change while mem_ren or mem_wen is 1.
REQ-022 Arbitration among simultaneous requests per REQ-034/035; a lone request SHALL always win.
REQ-023 A request that arrives during READ/WRITE/RELEASE SHALL wait and be considered in the next IDLE cycle; none lost.
REQ-024 At most one ack SHALL be high per cycle; ack of the loser SHALL stay 0.
REQ-025 If the winner drops reqN mid-transaction, the transaction SHALL complete and ackN still pulse (requester protocol violation, not aborted).
REQ-026 rdataN SHALL hold its last value until the next read granted to requester N completes; writes leave rdataN unchanged.
REQ-027 Minimum spacing between consecutive grants SHALL be one RELEASE cycle plus one IDLE cycle.

Reset
REQ-028 On reset low SHALL immediately enter IDLE, regardless of state.
REQ-029 During reset SHALL drive mem_ren=mem_wen=0, mem_addr=0, mem_din=0, ack0=ack1=0, rdata0=rdata1=0.
REQ-030 SHALL reset the round-robin pointer (if present) to favour requester 0.
REQ-031 A transaction interrupted by reset SHALL be discarded; no ack issued for it.
REQ-032 After reset release, first grant SHALL occur no earlier than the first rising edge with reset high.
REQ-033 Reset SHALL require no clock edge to take effect.

Configuration
REQ-034 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests SHALL grant the requester not granted last; pointer updates on every ack.
REQ-035 Macro undefined: SHALL use fixed priority, requester 0 always wins ties; requester 1 may starve; no pointer register.

Verification
REQ-036 Reset, req0=1 we0=0 addr0=5, memory word 5=0xA5A5 -> single ack0 with rdata0=0xA5A5; mem_ren high only from grant until ready; one RELEASE cycle with ren=wen=0.
REQ-037 req1=1 we1=1 addr1=9 wdata1=0x1234, then read addr 9 by req0 -> ack1 once, then rdata0=0x1234.
REQ-038 req0 and req1 both read, continuously held -> RR build: grants alternate 0,1,0,1; fixed build: requester 0 granted repeatedly, ack1 never.
REQ-039 req1 asserted while requester 0 write in progress -> no ack1 until ack0 + RELEASE + IDLE; then ack1 with correct data.
REQ-040 Reset asserted low mid-READ -> same cycle mem_ren=0, no ack; after release, new req0 completes normally.
REQ-041 Every cycle of all scenarios -> assertion: mem_ren&&mem_wen never 1; ack0&&ack1 never 1.
